// File: rtl/tdm_demux4_if.sv
// ============================================================================
//  Module      : tdm_demux4_if
//  Description : Input stream handshake and lane-buffer bundle for tdm_demux4
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface tdm_demux4_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             auto;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [3:0]       out_full;
    logic [3:0]       out_ack;
    logic [1:0]       cur_lane;
    logic             frame_done;

    // Source and lane consumers together form the master side
    modport master (
        output in_data, in_valid, auto, sel, out_ack,
        input  in_ready, out_data0, out_data1, out_data2, out_data3,
               out_full, cur_lane, frame_done
    );

    modport slave (
        input  in_data, in_valid, auto, sel, out_ack,
        output in_ready, out_data0, out_data1, out_data2, out_data3,
               out_full, cur_lane, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/tdm_demux4.sv
// ============================================================================
//  Module      : tdm_demux4
//  Description : Four-lane TDM demultiplexer with one-word lane buffers
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    tdm_demux4_if.slave   bus
);
    localparam logic [1:0] c_LAST_LANE = 2'd3;

    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_full;
    logic [1:0]       r_cur_lane;
    logic             r_frame_done;

    logic [1:0]       w_tgt;
    logic             w_ready;
    logic             w_xfer;
    logic [3:0]       w_wr;

    // A same-cycle ack frees the target lane, so ready never looks at in_valid
    assign w_tgt   = bus.auto ? r_cur_lane : bus.sel;
    assign w_ready = ~r_full[w_tgt] | bus.out_ack[w_tgt];
    assign w_xfer  = bus.in_valid & w_ready;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_wr[gi] = w_xfer && (w_tgt == 2'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data[gi] <= '0;
                    r_full[gi] <= 1'b0;
                end else if (w_wr[gi]) begin
                    r_data[gi] <= bus.in_data;
                    r_full[gi] <= 1'b1;
                end else if (bus.out_ack[gi]) begin
                    r_full[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_lane   <= 2'd0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_xfer && bus.auto) begin
                r_cur_lane <= r_cur_lane + 2'd1;
            end
            r_frame_done <= w_xfer && bus.auto && (r_cur_lane == c_LAST_LANE);
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.out_data0  = r_data[0];
    assign bus.out_data1  = r_data[1];
    assign bus.out_data2  = r_data[2];
    assign bus.out_data3  = r_data[3];
    assign bus.out_full   = r_full;
    assign bus.cur_lane   = r_cur_lane;
    assign bus.frame_done = r_frame_done;
endmodule

`default_nettype wire

// File: tb/tb_tdm_demux4.sv
// ============================================================================
//  Module      : tb_tdm_demux4
//  Description : Directed and randomized checks of tdm_demux4 (WIDTH 8 and 16)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    tdm_demux4_if #(.WIDTH(8))  bus8  ();
    tdm_demux4_if #(.WIDTH(16)) bus16 ();

    tdm_demux4 #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    tdm_demux4 #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lane16(input int i);
        case (i)
            0:       return bus16.out_data0;
            1:       return bus16.out_data1;
            2:       return bus16.out_data2;
            default: return bus16.out_data3;
        endcase
    endfunction

    // Reference model for the WIDTH=16 instance: lane occupancy, last word, pointer
    bit          m_full [4];
    logic [15:0] m_word [4];
    int          m_ptr;
    bit          m_fd;
    int          n_acc;
    int          n_con;

    initial begin
        logic [7:0] words [4];
        bit         stalled;
        int         tgt;
        bit         rdy;
        bit         xfer;
        int         outstanding;

        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        bus8.in_data = '0;  bus8.in_valid = 0;  bus8.auto = 0;  bus8.sel = 0;  bus8.out_ack = '0;
        bus16.in_data = '0; bus16.in_valid = 0; bus16.auto = 0; bus16.sel = 0; bus16.out_ack = '0;

        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        chk("rst_full",  bus8.out_full, 4'h0);
        chk("rst_cur",   bus8.cur_lane, 2'd0);
        chk("rst_fd",    bus8.frame_done, 1'b0);
        chk("rst_data0", bus8.out_data0, 8'h00);
        chk("rst_data3", bus8.out_data3, 8'h00);
        chk("rst_ready", bus8.in_ready, 1'b1);

        // Fill all four lanes in round-robin order
        bus8.auto = 1; bus8.in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus8.in_data = words[i];
            #1 chk("fill_ready", bus8.in_ready, 1'b1);
            tick;
            chk("fill_fd", bus8.frame_done, (i == 3) ? 1'b1 : 1'b0);
        end
        bus8.in_valid = 0;
        chk("fill_d0", bus8.out_data0, 8'h11);
        chk("fill_d1", bus8.out_data1, 8'h22);
        chk("fill_d2", bus8.out_data2, 8'h33);
        chk("fill_d3", bus8.out_data3, 8'h44);
        chk("fill_full", bus8.out_full, 4'hF);
        chk("fill_cur", bus8.cur_lane, 2'd0);
        chk("fill_ready_lo", bus8.in_ready, 1'b0);
        tick;
        chk("fd_once", bus8.frame_done, 1'b0);

        // Write into lane 0 while its consumer acknowledges
        bus8.in_valid = 1; bus8.in_data = 8'h55; bus8.out_ack = 4'b0001;
        #1 chk("wack_ready", bus8.in_ready, 1'b1);
        tick;
        bus8.in_valid = 0; bus8.out_ack = 4'b0000;
        chk("wack_d0", bus8.out_data0, 8'h55);
        chk("wack_full", bus8.out_full, 4'hF);
        chk("wack_cur", bus8.cur_lane, 2'd1);

        // Explicit select onto a full lane stalls until acked
        bus8.auto = 0; bus8.sel = 2'd2; bus8.in_valid = 1; bus8.in_data = 8'h99;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", bus8.in_ready, 1'b0);
            tick;
            chk("stall_d2", bus8.out_data2, 8'h33);
            chk("stall_cur", bus8.cur_lane, 2'd1);
        end
        bus8.out_ack = 4'b0100;
        #1 chk("unstall_ready", bus8.in_ready, 1'b1);
        tick;
        bus8.in_valid = 0; bus8.out_ack = 4'b0000;
        chk("unstall_d2", bus8.out_data2, 8'h99);
        chk("unstall_full", bus8.out_full, 4'hF);
        chk("unstall_cur", bus8.cur_lane, 2'd1);

        // Ack of an empty lane is harmless
        rst = 1'b1; tick; rst = 1'b0;
        bus8.out_ack = 4'b0010;
        tick;
        bus8.out_ack = 4'b0000;
        chk("empty_ack_full", bus8.out_full, 4'h0);
        chk("empty_ack_d1", bus8.out_data1, 8'h00);
        chk("empty_ack_cur", bus8.cur_lane, 2'd0);

        // Reset in mid-frame discards buffered words and the word on the input
        bus8.auto = 1; bus8.in_valid = 1;
        bus8.in_data = 8'hAA; tick;
        bus8.in_data = 8'hBB; tick;
        chk("mid_cur", bus8.cur_lane, 2'd2);
        bus8.in_data = 8'hCC; rst = 1'b1;
        tick;
        rst = 1'b0; bus8.in_valid = 0;
        chk("mid_full", bus8.out_full, 4'h0);
        chk("mid_d0", bus8.out_data0, 8'h00);
        chk("mid_d1", bus8.out_data1, 8'h00);
        chk("mid_d2", bus8.out_data2, 8'h00);
        chk("mid_cur0", bus8.cur_lane, 2'd0);
        chk("mid_fd", bus8.frame_done, 1'b0);
        tick;
        chk("mid_after_full", bus8.out_full, 4'h0);

        // Randomized traffic on the 16-bit instance
        rst = 1'b1; tick; rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 0;
            m_word[i] = '0;
        end
        m_ptr = 0; m_fd = 0; n_acc = 0; n_con = 0; stalled = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                chk("rnd_full", {31'd0, bus16.out_full[i]}, {31'd0, m_full[i]});
                chk("rnd_data", {16'd0, lane16(i)}, {16'd0, m_word[i]});
            end
            chk("rnd_cur", {30'd0, bus16.cur_lane}, m_ptr);
            chk("rnd_fd", {31'd0, bus16.frame_done}, {31'd0, m_fd});

            bus16.auto     = (c >= 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus16.sel      = 2'($urandom);
            bus16.in_valid = ($urandom_range(0, 3) != 0);
            bus16.out_ack  = 4'($urandom);
            if (!stalled) bus16.in_data = 16'($urandom);
            #1;

            tgt  = bus16.auto ? m_ptr : int'(bus16.sel);
            rdy  = !m_full[tgt] || bus16.out_ack[tgt];
            xfer = bus16.in_valid && rdy;
            chk("rnd_ready", {31'd0, bus16.in_ready}, {31'd0, rdy});

            for (int i = 0; i < 4; i++) begin
                if (bus16.out_ack[i] && m_full[i]) begin
                    n_con++;
                    m_full[i] = 0;
                end
            end
            if (xfer) begin
                n_acc++;
                m_full[tgt] = 1;
                m_word[tgt] = bus16.in_data;
            end
            m_fd = xfer && bus16.auto && (m_ptr == 3);
            if (xfer && bus16.auto) m_ptr = (m_ptr + 1) % 4;
            stalled = bus16.in_valid && !rdy;
            tick;
        end
        bus16.in_valid = 0; bus16.out_ack = '0;
        outstanding = 0;
        for (int i = 0; i < 4; i++) outstanding += int'(bus16.out_full[i]);
        chk("rnd_balance", n_acc - n_con, outstanding);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
